// File: rtl/serial_adder_ctrl_if.sv
// Handshake/result bundle for serial_adder_ctrl.
// master: requester side (drives start/operands); slave: the adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder built around a single 1-bit full-adder
// cell, LSB first, one bit per clock. IDLE -> RUN (WIDTH bit-cycles) -> DONE.
// Result (sum/cout/ovf) is published in one step on the last bit edge and
// held until the next completion.
// Optional feature: define SERIAL_ADDER_OVF_EN to build the signed-overflow
// flag; otherwise ovf is tied to 0 and no overflow logic exists.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] s_sh, s_shift;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r;
  logic             fa_s, fa_co, last, accept;

  // the one shared full-adder cell; operands shift right so bit[cnt] is at [0]
  assign fa_s  = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_co = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last  = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && bus.start;

  // partial sum collects bits 0..WIDTH-2 entering from the top
  if (WIDTH > 2) begin : g_sh
    assign s_shift = {fa_s, s_sh[WIDTH-2:1]};
  end else begin : g_sh1
    assign s_shift = fa_s;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: DONE always returns to IDLE, start only heard in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // operand capture, bit-serial datapath and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.op_a;
      b_sh  <= bus.op_b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_shift;
      carry <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum_r  <= {fa_s, s_sh};
        cout_r <= fa_co;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // signed overflow: carry into MSB xor carry out of MSB, updated with sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovf_r <= 1'b0;
    else if (state == RUN && last)  ovf_r <= carry ^ fa_co;
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

  // status decoded from the state register only
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock for all sequential logic; rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request an addition; sampled only in IDLE.
REQ-005 op_a  input  WIDTH  addend A; latched on the accepting edge.
REQ-006 op_b  input  WIDTH  addend B; latched on the accepting edge.
REQ-007 cin  input  1  carry-in to bit 0; latched on the accepting edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; the result is valid.
REQ-010 sum  output  WIDTH  registered result.
REQ-011 cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 ovf  output  1  signed overflow flag; see Configuration.

Function
REQ-013 The block SHALL compute op_a + op_b + cin using exactly one 1-bit full-adder cell (a, b, cin -> sum, cout) time-shared across all bit positions, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with transitions: IDLE->RUN on start=1; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally on the next edge.
REQ-015 The accepting edge SHALL latch op_a, op_b and cin into internal shift registers, clear the bit counter to 0 and load the carry register with cin.
REQ-016 In RUN, each edge SHALL feed bit[count] of both operands and the carry register to the FA, store the FA sum bit, update the carry register with the FA cout, and increment count.
REQ-017 The edge that processes bit WIDTH-1 SHALL update sum, cout and ovf in one step and enter DONE. done SHALL therefore be high for the single cycle that starts WIDTH edges after the accepting edge.
REQ-018 sum, cout and ovf SHALL hold their values from that edge until the next completion. Intermediate bits SHALL never appear on sum.
REQ-019 start SHALL be ignored in RUN and DONE, with no queuing. The earliest next acceptance is the edge after the controller returns to IDLE, giving a throughput of WIDTH+2 cycles per operation.
REQ-020 Changes on op_a, op_b and cin after the accepting edge SHALL NOT affect the result in flight.
REQ-021 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap inside an operation.
REQ-022 busy and done SHALL be mutually exclusive and SHALL be driven directly from state registers, with no combinational path from inputs.

Reset
REQ-023 When rst_n=0, the following SHALL be 0 immediately, independent of clk: the state (IDLE), busy, done, sum, cout, ovf, the counter, the carry register and the operand registers.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst_n deasserts SHALL behave exactly as after power-up.
REQ-025 The first clk edge with rst_n=1 SHALL be able to accept start.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN: when it is defined, ovf SHALL be the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1, registered with sum.
REQ-027 Without SERIAL_ADDER_OVF_EN, ovf SHALL be a constant 0, the port SHALL remain present, and no overflow logic SHALL be synthesized.

Verification
REQ-028 WIDTH=8, op_a=0x00, op_b=0x00, cin=0, start pulsed -> done high exactly 8 edges after acceptance, sum=0x00, cout=0; busy high for 8 cycles.
REQ-029 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-030 op_a=0x7F, op_b=0x01, cin=0 -> sum=0x80, cout=0; ovf=1 with SERIAL_ADDER_OVF_EN defined and ovf=0 without it.
REQ-031 Start 0x12+0x34, then pulse start with 0xAA+0x55 during RUN -> single done with sum=0x46; the second request is ignored, and busy/done show exactly one operation.
REQ-032 Start 0xF0+0x0F and drop rst_n at the 4th RUN cycle -> all outputs read 0 asynchronously and no done occurs. After release, 0x01+0x02 -> sum=0x03, done after 8 edges.
REQ-033 Random self-check of 1000 operations against the + operator, with operands changed every cycle during RUN -> zero mismatches; sum is stable between done pulses.
